imem_banked: RTL and testbench

- Parametrised multi-kernel instruction memory for the Filter-GPU fetch stage. It holds NUM_KERNELS independent program banks and gives each instruction a registered, one-cycle-latency read with a valid flag.
- Adds three things a plain ROM lacks: a runtime kernel switch with a one-cycle flush bubble, a loader write port for reprogramming banks, and error reporting for misaligned or out-of-range PCs.
- Sits between the PC register and the decode stage.

---
 rtl/imem_banked_if.sv | 36 +++
 rtl/imem_banked.sv | 107 ++++++++++
 tb/tb_imem_banked.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_banked_if.sv
// rtl/imem_banked_if.sv - fetch and loader bus for the banked instruction memory
interface imem_banked_if #(
  parameter int INSTR_W     = 28,
  parameter int DEPTH       = 64,
  parameter int NUM_KERNELS = 4
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int KSEL_W = $clog2(NUM_KERNELS);

  // fetch side
  logic               fetch_req;
  logic [31:0]        pc;
  logic [KSEL_W-1:0]  kernel;
  logic               stall;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               fetch_err;
  logic               busy;

  // loader side
  logic               ld_en;
  logic [KSEL_W-1:0]  ld_bank;
  logic [ADDR_W-1:0]  ld_addr;
  logic [INSTR_W-1:0] ld_data;
  logic               ld_err;

  modport master (
    output fetch_req, pc, kernel, stall, ld_en, ld_bank, ld_addr, ld_data,
    input  instr, instr_valid, fetch_err, busy, ld_err
  );

  modport slave (
    input  fetch_req, pc, kernel, stall, ld_en, ld_bank, ld_addr, ld_data,
    output instr, instr_valid, fetch_err, busy, ld_err
  );
endinterface

// File: rtl/imem_banked.sv
// rtl/imem_banked.sv - multi-kernel instruction memory with kernel switch, loader and fetch errors
module imem_banked #(
  parameter int INSTR_W     = 28,
  parameter int DEPTH       = 64,
  parameter int NUM_KERNELS = 4,
  parameter     INIT_FILE   = "memfile.dat"
) (
  input  logic         clk,
  input  logic         reset_n,
  imem_banked_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int KSEL_W = $clog2(NUM_KERNELS);
  // one spare bit so the range checks stay meaningful for non-power-of-2 sizes
  localparam logic [KSEL_W:0] NK = (KSEL_W+1)'(NUM_KERNELS);
  localparam logic [ADDR_W:0] ND = (ADDR_W+1)'(DEPTH);

  typedef enum logic {RUN, SWITCH} state_t;

  // banks laid out back to back: word address = {bank, index}
  logic [INSTR_W-1:0] mem [NUM_KERNELS*DEPTH];

  state_t             state;
  logic [KSEL_W-1:0]  active_kernel;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;
  logic               err_q;
  logic               ld_err_q;

  logic [ADDR_W-1:0]  idx;
  logic               pc_err;
  logic               kernel_bad;
  logic               ld_ok;
  logic               ld_hit;
  logic [INSTR_W-1:0] rd_data;

  assign idx        = bus.pc[ADDR_W+1:2];
  assign pc_err     = (bus.pc[1:0] != 2'b00) || (bus.pc[31:ADDR_W+2] != '0);
  assign kernel_bad = ({1'b0, bus.kernel} >= NK);
  assign ld_ok      = ({1'b0, bus.ld_bank} < NK) && ({1'b0, bus.ld_addr} < ND);
  // a same-cycle write to the word being fetched is forwarded (write-first)
  assign ld_hit     = bus.ld_en && ld_ok && (bus.ld_bank == active_kernel) && (bus.ld_addr == idx);
  assign rd_data    = ld_hit ? bus.ld_data : mem[{active_kernel, idx}];

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.fetch_err   = err_q;
  assign bus.busy        = (state == SWITCH);
  assign bus.ld_err      = ld_err_q;

  // loader write port; storage is deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (bus.ld_en && ld_ok) begin
      mem[{bus.ld_bank, bus.ld_addr}] <= bus.ld_data;
    end
  end

  // dropped-write indication, one cycle per rejected strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_err_q <= 1'b0;
    end else begin
      ld_err_q <= bus.ld_en && !ld_ok;
    end
  end

  // fetch FSM: serve matching-kernel requests, take a one-cycle bubble on a kernel change
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RUN;
      active_kernel <= '0;
      instr_q       <= '0;
      valid_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!bus.stall) begin
            if (!bus.fetch_req) begin
              valid_q <= 1'b0;
              err_q   <= 1'b0;
            end else if (kernel_bad) begin
              valid_q <= 1'b1;
              err_q   <= 1'b1;
              instr_q <= '0;
            end else if (bus.kernel != active_kernel) begin
              active_kernel <= bus.kernel;
              state         <= SWITCH;
              valid_q       <= 1'b0;
            end else begin
              valid_q <= 1'b1;
              err_q   <= pc_err;
              instr_q <= pc_err ? '0 : rd_data;
            end
          end
        end
        SWITCH: begin
          state <= RUN;
          if (!bus.stall) begin
            valid_q <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_banked.sv
// tb/tb_imem_banked.sv - directed scoreboard bench for imem_banked
module tb_imem_banked;
  localparam int INSTR_W = 28;
  localparam int DEPTH   = 64;
  localparam int NK      = 3;

  typedef struct {
    logic [INSTR_W-1:0] instr;
    logic               err;
  } exp_t;

  logic clk;
  logic reset_n;
  int   compared;
  int   mismatched;
  exp_t sb [$];
  logic [INSTR_W-1:0] model [NK][DEPTH];
  logic [INSTR_W-1:0] held;

  imem_banked_if #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .NUM_KERNELS(NK)) bus ();

  imem_banked #(
    .INSTR_W(INSTR_W), .DEPTH(DEPTH), .NUM_KERNELS(NK), .INIT_FILE("")
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input int k, input logic [31:0] p);
    exp_t e;
    logic [5:0] i;
    i = p[7:2];
    e.err = (p[1:0] != 2'b00) || (p[31:8] != 24'h0) || (k >= NK);
    e.instr = e.err ? '0 : model[k][i];
    return e;
  endfunction

  task automatic drive_fetch(input int k, input logic [31:0] p);
    bus.fetch_req = 1'b1;
    bus.kernel    = 2'(k);
    bus.pc        = p;
  endtask

  task automatic push_fetch(input int k, input logic [31:0] p);
    sb.push_back(predict(k, p));
  endtask

  task automatic check_fetch(input string tag);
    exp_t e;
    chk({tag, "_valid"}, {31'h0, bus.instr_valid}, 32'h1);
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_instr"}, {4'h0, bus.instr}, {4'h0, e.instr});
      chk({tag, "_err"}, {31'h0, bus.fetch_err}, {31'h0, e.err});
    end
  endtask

  task automatic load(input int b, input int a, input logic [INSTR_W-1:0] d, input logic exp_err);
    bus.ld_en   = 1'b1;
    bus.ld_bank = 2'(b);
    bus.ld_addr = 6'(a);
    bus.ld_data = d;
    if (!exp_err) model[b][a] = d;
    tick;
    chk("ld_err", {31'h0, bus.ld_err}, {31'h0, exp_err});
    bus.ld_en = 1'b0;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    reset_n = 1'b0;
    bus.fetch_req = 1'b0;
    bus.pc = '0;
    bus.kernel = '0;
    bus.stall = 1'b0;
    bus.ld_en = 1'b0;
    bus.ld_bank = '0;
    bus.ld_addr = '0;
    bus.ld_data = '0;
    repeat (3) tick;
    chk("rst_instr", {4'h0, bus.instr}, 32'h0);
    chk("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("rst_err", {31'h0, bus.fetch_err}, 32'h0);
    chk("rst_ld_err", {31'h0, bus.ld_err}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    reset_n = 1'b1;
    tick;

    for (int b = 0; b < NK; b++) begin
      for (int a = 0; a < 9; a++) begin
        load(b, (a == 8) ? 63 : a, INSTR_W'($urandom()), 1'b0);
      end
    end

    drive_fetch(0, 32'h8);
    push_fetch(0, 32'h8);
    tick;
    check_fetch("k0_pc8");
    chk("k0_busy", {31'h0, bus.busy}, 32'h0);

    drive_fetch(2, 32'h4);
    tick;
    chk("sw_busy1", {31'h0, bus.busy}, 32'h1);
    chk("sw_valid1", {31'h0, bus.instr_valid}, 32'h0);
    tick;
    chk("sw_busy2", {31'h0, bus.busy}, 32'h0);
    chk("sw_valid2", {31'h0, bus.instr_valid}, 32'h0);
    push_fetch(2, 32'h4);
    tick;
    check_fetch("k2_pc4");

    drive_fetch(2, 32'h6);
    push_fetch(2, 32'h6);
    tick;
    check_fetch("misalign");
    drive_fetch(2, 32'h100);
    push_fetch(2, 32'h100);
    tick;
    check_fetch("range_100");
    drive_fetch(2, 32'h8000_0000);
    push_fetch(2, 32'h8000_0000);
    tick;
    check_fetch("range_msb");
    drive_fetch(2, 32'hFC);
    push_fetch(2, 32'hFC);
    tick;
    check_fetch("last_word");

    drive_fetch(0, 32'h14);
    tick;
    chk("sw0_busy", {31'h0, bus.busy}, 32'h1);
    tick;
    chk("sw0_busy_clr", {31'h0, bus.busy}, 32'h0);
    bus.ld_en = 1'b1;
    bus.ld_bank = 2'd0;
    bus.ld_addr = 6'd5;
    bus.ld_data = 28'hABCDEF1;
    model[0][5] = 28'hABCDEF1;
    sb.push_back('{instr: 28'hABCDEF1, err: 1'b0});
    tick;
    check_fetch("collide");
    chk("collide_ld_err", {31'h0, bus.ld_err}, 32'h0);
    bus.ld_en = 1'b0;

    bus.fetch_req = 1'b0;
    tick;
    chk("idle_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("idle_err", {31'h0, bus.fetch_err}, 32'h0);
    chk("idle_instr", {4'h0, bus.instr}, 32'h0ABCDEF1);

    drive_fetch(0, 32'h14);
    push_fetch(0, 32'h14);
    tick;
    check_fetch("reread");

    bus.fetch_req = 1'b0;
    load(3, 5, 28'h1234567, 1'b1);
    tick;
    chk("ld_err_clr", {31'h0, bus.ld_err}, 32'h0);
    drive_fetch(0, 32'h14);
    push_fetch(0, 32'h14);
    tick;
    check_fetch("after_drop");

    drive_fetch(3, 32'h8);
    push_fetch(3, 32'h8);
    tick;
    check_fetch("bad_kernel1");
    chk("bad_kernel_busy1", {31'h0, bus.busy}, 32'h0);
    push_fetch(3, 32'h8);
    tick;
    check_fetch("bad_kernel2");
    chk("bad_kernel_busy2", {31'h0, bus.busy}, 32'h0);
    drive_fetch(0, 32'h8);
    push_fetch(0, 32'h8);
    tick;
    check_fetch("k0_after_bad");

    drive_fetch(0, 32'h0);
    push_fetch(0, 32'h0);
    held = model[0][0];
    tick;
    check_fetch("pre_stall");
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.pc = 32'(4 * (i + 1));
      tick;
      chk("stall_valid", {31'h0, bus.instr_valid}, 32'h1);
      chk("stall_instr", {4'h0, bus.instr}, {4'h0, held});
      chk("stall_err", {31'h0, bus.fetch_err}, 32'h0);
    end
    bus.stall = 1'b0;
    bus.pc = 32'h1C;
    push_fetch(0, 32'h1C);
    tick;
    check_fetch("post_stall");

    drive_fetch(1, 32'h8);
    tick;
    chk("sw1_busy", {31'h0, bus.busy}, 32'h1);
    bus.stall = 1'b1;
    tick;
    chk("sw1_stall_busy", {31'h0, bus.busy}, 32'h0);
    chk("sw1_stall_valid", {31'h0, bus.instr_valid}, 32'h0);
    bus.stall = 1'b0;
    push_fetch(1, 32'h8);
    tick;
    check_fetch("k1_after_stalled_switch");

    drive_fetch(2, 32'h10);
    tick;
    chk("sw2_busy", {31'h0, bus.busy}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("mid_rst_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("mid_rst_instr", {4'h0, bus.instr}, 32'h0);
    tick;
    reset_n = 1'b1;
    drive_fetch(0, 32'h4);
    push_fetch(0, 32'h4);
    tick;
    check_fetch("post_rst_k0");
    chk("post_rst_busy", {31'h0, bus.busy}, 32'h0);

    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
